fifo_sync_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's 16-bit/8-bit buffer FIFO.
- Generalised data width and depth; full flag is exact at any depth.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered read port.
- Sits between producer and consumer blocks in one clock domain; the memory is a separate two-port RAM sub-module.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram_2p.sv | 28 ++
 rtl/fifo_sync_param.sv | 114 +++++++++++
 tb/tb_fifo_sync_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Occupancy counter width: one extra bit so DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port register-array RAM: synchronous write, asynchronous read.
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store wdata at waddr when enabled; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with exact full flag, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// registered read port.
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through; removes the
// output register and presents the head word combinationally).
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 2,
    localparam int ADDR_W   = clog2(DEPTH),
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              W,
    output logic              Full,
    output logic              AlmostFull,
    output logic [DATA_W-1:0] DataOut,
    input  logic              R,
    output logic              Empty,
    output logic              AlmostEmpty,
    output logic [CNT_W-1:0]  Count,
    input  logic              ErrClr,
    output logic              Overflow,
    output logic              Underflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    logic [ADDR_W-1:0] wpointer;
    logic [ADDR_W-1:0] rpointer;
    logic [DATA_W-1:0] rdata;
    logic              wr_ok;
    logic              rd_ok;

    assign Full        = (Count == FULL_CNT);
    assign Empty       = (Count == '0);
    assign AlmostFull  = (Count >= AF_CNT);
    assign AlmostEmpty = (Count <= AE_CNT);

    assign wr_ok = W & ~Full;
    assign rd_ok = R & ~Empty;

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (Clk),
        .we    (wr_ok),
        .waddr (wpointer),
        .wdata (DataIn),
        .raddr (rpointer),
        .rdata (rdata)
    );

    // Pointers advance on accepted transfers; power-of-two depth gives natural wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wpointer <= '0;
            rpointer <= '0;
        end else begin
            if (wr_ok) wpointer <= wpointer + ADDR_W'(1);
            if (rd_ok) rpointer <= rpointer + ADDR_W'(1);
        end
    end

    // Occupancy: simultaneous accepted read and write leave it unchanged.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   Count <= Count + CNT_W'(1);
                2'b01:   Count <= Count - CNT_W'(1);
                default: Count <= Count;
            endcase
        end
    end

    // Sticky error flags; a new error on the same edge as ErrClr wins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow  <= (W & Full)  | (Overflow  & ~ErrClr);
            Underflow <= (R & Empty) | (Underflow & ~ErrClr);
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly from the RAM; zero while empty.
    always_comb begin
        DataOut = '0;
        if (!Empty) DataOut = rdata;
    end
`else
    // Registered read port: capture the head word on an accepted read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DataOut <= '0;
        end else if (rd_ok) begin
            DataOut <= rdata;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DATA_W=16, DEPTH=16, AF=12, AE=2).
// Builds for either read mode; FIFO_FWFT_EN selects the fall-through model.
module tb_fifo_sync_param;

    localparam int DW    = 16;
    localparam int DEP   = 16;
    localparam int AF_T  = 12;
    localparam int AE_T  = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] DataIn;
    logic          W;
    logic          R;
    logic          ErrClr;
    logic          Full;
    logic          AlmostFull;
    logic [DW-1:0] DataOut;
    logic          Empty;
    logic          AlmostEmpty;
    logic [4:0]    Count;
    logic          Overflow;
    logic          Underflow;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;

    fifo_sync_param #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .AF_THRESH (AF_T),
        .AE_THRESH (AE_T)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DataIn      (DataIn),
        .W           (W),
        .Full        (Full),
        .AlmostFull  (AlmostFull),
        .DataOut     (DataOut),
        .R           (R),
        .Empty       (Empty),
        .AlmostEmpty (AlmostEmpty),
        .Count       (Count),
        .ErrClr      (ErrClr),
        .Overflow    (Overflow),
        .Underflow   (Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        if (m_q.size() == 0) return '0;
        return m_q[0];
`else
        return m_dout;
`endif
    endfunction

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".count"},  32'(Count),       32'(n));
        chk({tag, ".full"},   32'(Full),        32'(n == DEP));
        chk({tag, ".empty"},  32'(Empty),       32'(n == 0));
        chk({tag, ".afull"},  32'(AlmostFull),  32'(n >= AF_T));
        chk({tag, ".aempty"}, 32'(AlmostEmpty), 32'(n <= AE_T));
        chk({tag, ".ovf"},    32'(Overflow),    32'(m_ovf));
        chk({tag, ".unf"},    32'(Underflow),   32'(m_unf));
        chk({tag, ".dout"},   32'(DataOut),     32'(exp_dout()));
    endtask

    // One clock: drive inputs, update reference at the edge, check just after.
    task automatic step(input string tag, input logic w_i, input logic r_i,
                        input logic [DW-1:0] d_i, input logic clr_i);
        bit full_m, empty_m;
        W = w_i; R = r_i; DataIn = d_i; ErrClr = clr_i;
        @(posedge Clk);
        full_m  = (m_q.size() == DEP);
        empty_m = (m_q.size() == 0);
        if (r_i && !empty_m) m_dout = m_q.pop_front();
        if (w_i && !full_m)  m_q.push_back(d_i);
        m_ovf = (w_i && full_m)  || (m_ovf && !clr_i);
        m_unf = (r_i && empty_m) || (m_unf && !clr_i);
        #1;
        check_all(tag);
        W = 1'b0; R = 1'b0; ErrClr = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        Reset = 1'b1; W = 1'b0; R = 1'b0; ErrClr = 1'b0;
        #1;
        m_q.delete();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        check_all(tag);
        chk({tag, ".dout0"}, 32'(DataOut), 32'h0);
        chk({tag, ".cnt0"},  32'(Count),   32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        DataIn = '0;
        apply_reset("reset");

        for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 16'h0, 1'b0);

        // Fill to full, then overflow attempt.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, DW'(16'h1000 + i), 1'b0);
        chk("fill.full_const", 32'(Full), 32'h1);
        step("ovf", 1'b1, 1'b0, 16'hDEAD, 1'b0);
        chk("ovf.cnt_const", 32'(Count), 32'd16);

        // Drain in order, then underflow and clear.
        for (int i = 0; i < 16; i++) begin
            step("drain", 1'b0, 1'b1, 16'h0, 1'b0);
`ifndef FIFO_FWFT_EN
            chk("drain.seq", 32'(DataOut), 32'(16'h1000 + i));
`endif
        end
        step("unf", 1'b0, 1'b1, 16'h0, 1'b0);
        chk("unf.const", 32'(Underflow), 32'h1);
        step("errclr", 1'b0, 1'b0, 16'h0, 1'b1);

        // Half full, then steady streaming with pointer wrap.
        for (int i = 0; i < 8; i++)  step("half", 1'b1, 1'b0, DW'(16'h2000 + i), 1'b0);
        for (int i = 0; i < 40; i++) step("stream", 1'b1, 1'b1, DW'(16'h3000 + i), 1'b0);
        chk("stream.cnt_const", 32'(Count), 32'd8);

        // Full with W=R: read wins, overflow sets even with ErrClr on the same edge.
        for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, DW'(16'h4000 + i), 1'b0);
        step("full_wr", 1'b1, 1'b1, 16'hBEEF, 1'b1);
        chk("full_wr.cnt_const", 32'(Count), 32'd15);

        // Empty with W=R: write wins, underflow sets.
        for (int i = 0; i < 15; i++) step("drain2", 1'b0, 1'b1, 16'h0, 1'b0);
        step("empty_wr", 1'b1, 1'b1, 16'h5555, 1'b0);
        chk("empty_wr.cnt_const", 32'(Count), 32'd1);
        step("pop1", 1'b0, 1'b1, 16'h0, 1'b1);

        // Single word into an empty FIFO, then acknowledge.
        step("abcd_w", 1'b1, 1'b0, 16'hABCD, 1'b0);
`ifdef FIFO_FWFT_EN
        chk("fwft.head", 32'(DataOut), 32'hABCD);
`endif
        step("abcd_r", 1'b0, 1'b1, 16'h0, 1'b0);

        // Asynchronous reset mid-fill.
        for (int i = 0; i < 5; i++) step("prefill", 1'b1, 1'b0, DW'(16'h6000 + i), 1'b0);
        #2;
        apply_reset("midrst");
        step("post_rst", 1'b0, 1'b0, 16'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
